// File: rtl/quick_spi_arbiter_pkg.sv
// Shared types for the quick_spi round-robin arbiter.
package quick_spi_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ABORT  = 3'd4
  } state_t;

endpackage

// File: rtl/quick_spi_arbiter_rr_picker.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module quick_spi_arbiter_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_next,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);

  int idx;

  always_comb begin
    grant_next = '0;
    winner     = '0;
    valid      = 1'b0;
    idx        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid && req[idx]) begin
        valid           = 1'b1;
        winner          = PTR_W'(idx);
        grant_next[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/quick_spi_arbiter.sv
// Round-robin sequencer sharing one quick_spi master among NUM_REQ requesters,
// with a watchdog that aborts transactions whose end never arrives.
module quick_spi_arbiter
  import quick_spi_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int SLAVE_WIDTH    = 2,
  parameter int OUT_WIDTH      = 16,
  parameter int IN_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*SLAVE_WIDTH-1:0] req_slave,
  input  logic [NUM_REQ-1:0]             req_operation,
  input  logic [NUM_REQ*OUT_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic [NUM_REQ-1:0]             error,
  output logic [IN_WIDTH-1:0]            rdata,
  output logic                           busy,
  output logic                           spi_enable,
  output logic                           spi_start,
  output logic [SLAVE_WIDTH-1:0]         spi_slave,
  output logic                           spi_operation,
  output logic [OUT_WIDTH-1:0]           spi_outgoing_data,
  input  logic                           spi_end,
  input  logic [IN_WIDTH-1:0]            spi_incoming_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [TMR_W-1:0]   timer;
  logic [NUM_REQ-1:0] pick_grant;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [PTR_W-1:0]   next_ptr;

  quick_spi_arbiter_rr_picker #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_picker (
    .req       (req),
    .ptr       (ptr),
    .grant_next(pick_grant),
    .winner    (pick_idx),
    .valid     (pick_valid)
  );

  // The winner drops to lowest priority for the next round.
  assign next_ptr = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      ptr               <= '0;
      timer             <= '0;
      grant             <= '0;
      done              <= '0;
      error             <= '0;
      rdata             <= '0;
      busy              <= 1'b0;
      spi_enable        <= 1'b0;
      spi_start         <= 1'b0;
      spi_slave         <= '0;
      spi_operation     <= 1'b0;
      spi_outgoing_data <= '0;
    end else begin
      done      <= '0;
      error     <= '0;
      spi_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state             <= ST_LAUNCH;
            grant             <= pick_grant;
            ptr               <= next_ptr;
            timer             <= '0;
            busy              <= 1'b1;
            spi_enable        <= 1'b1;
            spi_start         <= 1'b1;
            spi_slave         <= req_slave[pick_idx*SLAVE_WIDTH +: SLAVE_WIDTH];
            spi_operation     <= req_operation[pick_idx];
            spi_outgoing_data <= req_wdata[pick_idx*OUT_WIDTH +: OUT_WIDTH];
          end
        end
        ST_LAUNCH: begin
          // Timer counts cycles since LAUNCH, so ABORT lands TIMEOUT_CYCLES after it.
          state <= ST_WAIT;
          timer <= timer + 1'b1;
        end
        ST_WAIT: begin
          if (spi_end) begin
            rdata      <= spi_incoming_data;
            done       <= grant;
            spi_enable <= 1'b0;
            state      <= ST_DONE;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            error      <= grant;
            spi_enable <= 1'b0;
            state      <= ST_ABORT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DONE, ST_ABORT: begin
          state <= ST_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// Self-checking bench for quick_spi_arbiter: directed round-robin, read/write,
// timeout, reset and spurious-end scenarios with a completion scoreboard.
module tb_quick_spi_arbiter;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int OW = 16;
  localparam int IW = 8;
  localparam int T  = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*SW-1:0] req_slave;
  logic [N-1:0]    req_operation;
  logic [N*OW-1:0] req_wdata;
  logic [N-1:0]    grant, done, error;
  logic [IW-1:0]   rdata;
  logic            busy, spi_enable, spi_start, spi_operation, spi_end;
  logic [SW-1:0]   spi_slave;
  logic [OW-1:0]   spi_outgoing_data;
  logic [IW-1:0]   spi_incoming_data;

  // Scoreboard entry: {is_error, owner one-hot, rdata}
  logic [12:0]   exp_q[$];
  logic [SW-1:0] m_slave[N];
  logic          m_op[N];
  logic [OW-1:0] m_wdata[N];
  logic [IW-1:0] last_rdata;
  int            n_checks = 0;
  int            n_fail   = 0;

  quick_spi_arbiter #(
    .NUM_REQ(N), .SLAVE_WIDTH(SW), .OUT_WIDTH(OW), .IN_WIDTH(IW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_slave(req_slave),
    .req_operation(req_operation), .req_wdata(req_wdata), .grant(grant),
    .done(done), .error(error), .rdata(rdata), .busy(busy),
    .spi_enable(spi_enable), .spi_start(spi_start), .spi_slave(spi_slave),
    .spi_operation(spi_operation), .spi_outgoing_data(spi_outgoing_data),
    .spi_end(spi_end), .spi_incoming_data(spi_incoming_data)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Completion monitor
  always @(negedge clk) begin
    logic [12:0] e;
    if (!reset && (|done || |error)) begin
      if (exp_q.size() == 0) begin
        check("unexp_pulse", 32'({error, done}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", 32'({|error, done | error, rdata}), 32'(e));
      end
    end
  end

  // Driver tasks
  task automatic set_req(input int i, input logic [SW-1:0] s, input logic o, input logic [OW-1:0] w);
    m_slave[i] = s;
    m_op[i]    = o;
    m_wdata[i] = w;
    req_slave[i*SW +: SW] = s;
    req_operation[i]      = o;
    req_wdata[i*OW +: OW] = w;
    req[i]                = 1'b1;
  endtask

  task automatic wait_launch(output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (spi_start) seen = 1'b1;
    end
    check("launch_seen", 32'(seen), 32'd1);
  endtask

  // Waits for a launch expected for requester idx, checks latched fields and answers.
  task automatic serve(input int idx, input logic [IW-1:0] din, input int lat,
                       input bit drop_mid, output int n);
    bit seen;
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    wait_launch(n, seen);
    if (seen) begin
      check("grant", 32'(grant), 32'(oh));
      check("spi_slave", 32'(spi_slave), 32'(m_slave[idx]));
      check("spi_op", 32'(spi_operation), 32'(m_op[idx]));
      check("spi_wdata", 32'(spi_outgoing_data), 32'(m_wdata[idx]));
      check("launch_enable", 32'({busy, spi_enable}), 32'd3);
      @(negedge clk);
      if (drop_mid) req[idx] = 1'b0;
      check("start_pulse", 32'({spi_start, spi_enable}), 32'd1);
      repeat (lat - 1) @(negedge clk);
      spi_incoming_data = din;
      spi_end = 1'b1;
      exp_q.push_back({1'b0, oh, din});
      last_rdata = din;
      @(negedge clk);
      spi_end = 1'b0;
      check("done_lat", 32'(done), 32'(oh));
      check("done_grant", 32'({grant, spi_enable}), 32'({oh, 1'b0}));
    end
  endtask

  initial begin
    int n;
    bit seen;
    reset = 1'b1;
    req = '0;
    req_slave = '0;
    req_operation = '0;
    req_wdata = '0;
    spi_end = 1'b0;
    spi_incoming_data = '0;
    last_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({grant, done, error, busy, spi_enable, spi_start}), 32'd0);
    check("reset_data", 32'({rdata, spi_slave, spi_outgoing_data}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: single write from requester 1
    set_req(1, 2'b01, 1'b1, 16'h5A5A);
    serve(1, 8'h11, 40, 1'b0, n);
    check("t1_launch_lat", 32'(n), 32'd1);
    req[1] = 1'b0;
    @(negedge clk);
    check("t1_idle", 32'({grant, busy, spi_enable}), 32'd0);

    // 2: read from requester 2
    set_req(2, 2'b10, 1'b0, 16'h1234);
    serve(2, 8'hC3, 5, 1'b0, n);
    check("t2_rdata", 32'(rdata), 32'h0000_00C3);
    req[2] = 1'b0;
    @(negedge clk);
    check("t2_rdata_held", 32'(rdata), 32'h0000_00C3);

    // 3: all requesting after reset -> 0,1,2,3,0 with one IDLE between
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_rdata = '0;
    for (int i = 0; i < N; i++)
      set_req(i, SW'(i), 1'(i), OW'(16'hA000 + i));
    for (int k = 0; k < 5; k++) begin
      serve(k % N, 8'($urandom_range(0, 255)), int'($urandom_range(1, 6)), 1'b0, n);
      if (k > 0) check("t3_b2b_gap", 32'(n), 32'd2);
    end
    req = '0;
    @(negedge clk);

    // 4: timeout on requester 3
    set_req(3, 2'b11, 1'b1, 16'hBEEF);
    wait_launch(n, seen);
    check("t4_grant", 32'(grant), 32'b1000);
    exp_q.push_back({1'b1, 4'b1000, last_rdata});
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < T + 10 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (|error) seen = 1'b1;
    end
    check("t4_timeout_cycles", 32'(n), 32'(T));
    check("t4_abort_enable", 32'({spi_enable, done}), 32'd0);
    req[3] = 1'b0;
    @(negedge clk);
    check("t4_after", 32'({busy, spi_enable, grant, error}), 32'd0);

    // 5: reset in WAIT, then requester 0 wins over 2
    set_req(2, 2'b01, 1'b0, 16'h7777);
    wait_launch(n, seen);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_reset_ctl", 32'({grant, done, error, busy, spi_enable, spi_start}), 32'd0);
    check("t5_reset_data", 32'({rdata, spi_slave, spi_operation, spi_outgoing_data}), 32'd0);
    reset = 1'b0;
    last_rdata = '0;
    set_req(0, 2'b10, 1'b1, 16'h0F0F);
    serve(0, 8'h5C, 3, 1'b0, n);
    req[0] = 1'b0;
    serve(2, 8'h77, 2, 1'b0, n);
    req[2] = 1'b0;
    @(negedge clk);

    // 6: spurious spi_end in IDLE and owner dropping req mid-WAIT
    spi_incoming_data = 8'hEE;
    spi_end = 1'b1;
    @(negedge clk);
    spi_end = 1'b0;
    @(negedge clk);
    check("t6_spurious_idle", 32'({busy, rdata}), 32'(last_rdata));
    set_req(1, 2'b00, 1'b0, 16'hCAFE);
    serve(1, 8'h96, 7, 1'b1, n);
    @(negedge clk);
    check("t6_no_rearb", 32'({busy, grant}), 32'd0);
    spi_incoming_data = 8'h42;
    spi_end = 1'b1;
    @(negedge clk);
    spi_end = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rdata_kept", 32'({busy, rdata}), 32'h0000_0096);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
